// File: rtl/btn_debounce_4ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_4ch
//
// Push-button conditioner for the seven-segment front end. Each raw pad level
// passes through a two-flop synchroniser. The synchronised sample must then
// disagree with the current debounced level for STABLE_CYCLES consecutive
// samples before the new level is accepted. Accepted transitions produce
// registered one-cycle press/release pulses.
//
// Optional feature macro: BTN_DEBOUNCE_REPEAT_EN
//   When defined, a held button re-issues btn_press. The first repeat comes
//   REPEAT_DELAY cycles after the press is accepted. Later repeats come every
//   REPEAT_PERIOD cycles. When undefined, no repeat logic is built.
//
// Ports:
//   clk          system clock (10 MHz nominal)
//   rst_n        asynchronous active-low reset, clears all state
//   ena          pulse enable; filtering continues while low
//   btn_raw      raw button levels, asynchronous to clk, active high
//   btn_level    debounced level per channel
//   btn_press    one-cycle pulse on accepted 0->1 (and repeats, if enabled)
//   btn_release  one-cycle pulse on accepted 1->0
//   any_press    registered OR of btn_press, one cycle later
// -----------------------------------------------------------------------------
module btn_debounce_4ch #(
    parameter int NUM_BTN       = 4,
    parameter int CNT_W         = 16,
    parameter int STABLE_CYCLES = 10000,
    parameter int RPT_W         = 24,
    parameter int REPEAT_DELAY  = 5000000,
    parameter int REPEAT_PERIOD = 2000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               any_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Configuration sanity checks, raised at elaboration.
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_stable
        $error("btn_debounce_4ch: STABLE_CYCLES=%0d outside 2..2^CNT_W-1", STABLE_CYCLES);
    end

    // The repeat timing is checked in both builds. Defining the macro then
    // never turns a configuration that elaborates into one that does not.
    if (REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD ||
        REPEAT_DELAY > (2 ** RPT_W) - 1) begin : g_bad_repeat
        $error("btn_debounce_4ch: repeat timing does not fit RPT_W");
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_ch
            logic             r_sync1;
            logic             r_sync2;
            logic             r_level;
            logic             r_press;
            logic             r_release;
            logic [CNT_W-1:0] r_cnt;
            logic             w_differ;
            logic             w_accept;
            logic             w_rpt_fire;

            assign w_differ = r_sync2 ^ r_level;
            // The last of STABLE_CYCLES disagreeing samples commits the new level.
            assign w_accept = w_differ && (r_cnt == CNT_LAST);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= btn_raw[gi];
                    r_sync2 <= r_sync1;
                end
            end

            // A single agreeing sample (bounce) restarts the count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (!w_differ) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_cnt   <= '0;
                    r_level <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end

`ifdef BTN_DEBOUNCE_REPEAT_EN
            logic [RPT_W-1:0] r_rpt;

            // Repeats only while the level is settled high. The cycle that
            // accepts a release is excluded, so press and release stay
            // exclusive.
            assign w_rpt_fire = r_level && !w_accept && (r_rpt == RPT_FIRE);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rpt <= '0;
                end else if (!r_level || w_accept) begin
                    r_rpt <= '0;
                end else if (w_rpt_fire) begin
                    r_rpt <= RPT_RELOAD;
                end else begin
                    r_rpt <= r_rpt + RPT_ONE;
                end
            end
`else
            assign w_rpt_fire = 1'b0;
`endif

            // Pulses are registered alongside the level update, so they
            // coincide with the first cycle the new level is visible.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_press   <= ena && ((w_accept && !r_level) || w_rpt_fire);
                    r_release <= ena && w_accept && r_level;
                end
            end

            assign btn_level[gi]   = r_level;
            assign btn_press[gi]   = r_press;
            assign btn_release[gi] = r_release;
        end
    endgenerate

    logic r_any_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |btn_press;
        end
    end

    assign any_press = r_any_press;

endmodule
